// File: rtl/xem_pipe_channel_bridge.sv
// Multi-channel Opal Kelly pipe bridge: framed inbound packets are routed to per-channel
// valid/ready streams, and round-robin fixed-length bursts are gathered into the pipe-out FIFO.
module xem_pipe_channel_bridge_fifo #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    output logic [15:0]   head,
    output logic [AW:0]   count
);
    localparam int CW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [15:0]   head_reg;
    logic          push, pop;

    assign push        = wr_en && (count_reg != CW'(DEPTH));
    assign pop         = rd_en && (count_reg != '0);
    assign rd_ptr_next = rd_ptr_reg + AW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= wr_data;
    end

    // Head register reads the next slot; a word written into that very slot is bypassed.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_reg + CW'(push) - CW'(pop);
            head_reg   <= (push && (wr_ptr_reg == rd_ptr_next)) ? wr_data : mem[rd_ptr_next];
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
endmodule

module xem_pipe_channel_bridge #(
    parameter int NUM_CH          = 4,
    parameter int BUFF_ADDR_WIDTH = 11,
    parameter int BURST_LEN       = 16
) (
    input  logic                 ti_clk,
    input  logic                 ti_soft_rst,
    input  logic                 ti_in_data_en,
    input  logic [15:0]          ti_in_data,
    output logic [15:0]          ti_in_available,
    input  logic                 ti_out_data_en,
    output logic [15:0]          ti_out_data,
    output logic [15:0]          ti_out_available,
    output logic [NUM_CH-1:0]    ch_rx_valid,
    output logic [15:0]          ch_rx_data,
    input  logic [NUM_CH-1:0]    ch_rx_ready,
    input  logic [NUM_CH-1:0]    ch_tx_valid,
    input  logic [16*NUM_CH-1:0] ch_tx_data,
    output logic [NUM_CH-1:0]    ch_tx_ready,
    output logic [15:0]          status
);
    localparam int              AW         = BUFF_ADDR_WIDTH;
    localparam int              CW         = AW + 1;
    localparam logic [CW-1:0]   DEPTH      = CW'(1 << AW);
    localparam logic [CW-1:0]   TX_NEED    = CW'(BURST_LEN + 1);
    localparam logic [11:0]     BURST_HDR  = 12'(BURST_LEN);
    localparam logic [11:0]     BURST_LAST = 12'(BURST_LEN - 1);

    typedef enum logic [1:0] {R_HDR, R_DATA, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_state_t;

    logic [15:0]   in_head, out_head, out_wdata, tx_word;
    logic [AW:0]   in_count, out_count, out_free;
    logic          in_empty, in_full, out_empty, in_pop, out_push;

    rx_state_t     rx_state_reg, rx_state_next;
    logic [3:0]    rx_ch_reg, rx_ch_next;
    logic [11:0]   rx_len_reg, rx_len_next;
    logic          bad_ch_set, rx_ready_sel, rx_busy;
    logic [NUM_CH-1:0] rx_sel, tx_sel;

    tx_state_t     tx_state_reg, tx_state_next;
    logic [3:0]    grant_reg, grant_next, last_grant_reg, last_grant_next, rr_pick;
    logic [11:0]   tx_cnt_reg, tx_cnt_next;
    logic          rr_any, tx_hs;
    logic [15:0]   tx_masked [NUM_CH];

    logic          overflow_reg, underflow_reg, bad_ch_reg;

    xem_pipe_channel_bridge_fifo #(.AW(AW)) u_in_fifo (
        .clk(ti_clk), .srst(ti_soft_rst), .wr_en(ti_in_data_en), .wr_data(ti_in_data),
        .rd_en(in_pop), .head(in_head), .count(in_count)
    );

    xem_pipe_channel_bridge_fifo #(.AW(AW)) u_out_fifo (
        .clk(ti_clk), .srst(ti_soft_rst), .wr_en(out_push), .wr_data(out_wdata),
        .rd_en(ti_out_data_en), .head(out_head), .count(out_count)
    );

    assign in_empty         = (in_count == '0);
    assign in_full          = (in_count == DEPTH);
    assign out_empty        = (out_count == '0);
    assign out_free         = DEPTH - out_count;
    assign ti_in_available  = 16'(DEPTH - in_count);
    assign ti_out_available = 16'(out_count);
    assign ti_out_data      = out_empty ? 16'h0000 : out_head;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign rx_sel[gi]    = (rx_ch_reg == 4'(gi));
            assign tx_sel[gi]    = (grant_reg == 4'(gi));
            assign tx_masked[gi] = tx_sel[gi] ? ch_tx_data[16*gi +: 16] : 16'h0000;
        end
    endgenerate

    // ---------------- inbound ----------------
    always_ff @(posedge ti_clk) begin
        if (ti_soft_rst) begin
            rx_state_reg <= R_HDR;
            rx_ch_reg    <= '0;
            rx_len_reg   <= '0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_ch_reg    <= rx_ch_next;
            rx_len_reg   <= rx_len_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_ch_next    = rx_ch_reg;
        rx_len_next   = rx_len_reg;
        bad_ch_set    = 1'b0;
        case (rx_state_reg)
            R_HDR: if (!in_empty) begin
                rx_ch_next  = in_head[15:12];
                rx_len_next = in_head[11:0];
                if (in_head[11:0] == 12'd0)
                    rx_state_next = R_HDR;
                else if ({1'b0, in_head[15:12]} >= 5'(NUM_CH)) begin
                    rx_state_next = R_DROP;
                    bad_ch_set    = 1'b1;
                end else
                    rx_state_next = R_DATA;
            end
            R_DATA, R_DROP: if (in_pop) begin
                rx_len_next = rx_len_reg - 12'd1;
                if (rx_len_reg == 12'd1)
                    rx_state_next = R_HDR;
            end
            default: rx_state_next = R_HDR;
        endcase
    end

    always_comb begin
        rx_ready_sel = |(ch_rx_ready & rx_sel);
        rx_busy      = (rx_state_reg != R_HDR);
        ch_rx_data   = in_head;
        ch_rx_valid  = (rx_state_reg == R_DATA && !in_empty) ? rx_sel : '0;
        in_pop       = !in_empty && ((rx_state_reg == R_DATA) ? rx_ready_sel : 1'b1);
    end

    // ---------------- outbound ----------------
    // Distance from last_grant+1 (mod NUM_CH); the smallest distance among valid channels wins.
    always_comb begin
        int best_d;
        int d;
        best_d  = NUM_CH;
        d       = 0;
        rr_any  = 1'b0;
        rr_pick = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            d = c - int'(last_grant_reg) - 1;
            if (d < 0)
                d = d + NUM_CH;
            if (ch_tx_valid[c] && d < best_d) begin
                best_d  = d;
                rr_pick = 4'(c);
                rr_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge ti_clk) begin
        if (ti_soft_rst) begin
            tx_state_reg   <= T_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= 4'(NUM_CH - 1);
            tx_cnt_reg     <= '0;
        end else begin
            tx_state_reg   <= tx_state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            tx_cnt_reg     <= tx_cnt_next;
        end
    end

    // The header plus a whole burst must fit before granting, so T_DATA never meets a full FIFO.
    always_comb begin
        tx_state_next   = tx_state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        tx_cnt_next     = tx_cnt_reg;
        case (tx_state_reg)
            T_IDLE: if (rr_any && out_free >= TX_NEED) begin
                grant_next    = rr_pick;
                tx_state_next = T_HDR;
            end
            T_HDR: begin
                tx_cnt_next   = '0;
                tx_state_next = T_DATA;
            end
            T_DATA: if (tx_hs) begin
                tx_cnt_next = tx_cnt_reg + 12'd1;
                if (tx_cnt_reg == BURST_LAST) begin
                    last_grant_next = grant_reg;
                    tx_state_next   = T_IDLE;
                end
            end
            default: tx_state_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_word = 16'h0000;
        for (int c = 0; c < NUM_CH; c++)
            tx_word = tx_word | tx_masked[c];
        ch_tx_ready = (tx_state_reg == T_DATA) ? tx_sel : '0;
        tx_hs       = |(ch_tx_valid & ch_tx_ready);
        out_push    = (tx_state_reg == T_HDR) || tx_hs;
        out_wdata   = (tx_state_reg == T_HDR) ? {grant_reg, BURST_HDR} : tx_word;
    end

    // ---------------- sticky status ----------------
    always_ff @(posedge ti_clk) begin
        if (ti_soft_rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            bad_ch_reg    <= 1'b0;
        end else begin
            overflow_reg  <= overflow_reg  | (ti_in_data_en && in_full);
            underflow_reg <= underflow_reg | (ti_out_data_en && out_empty);
            bad_ch_reg    <= bad_ch_reg    | bad_ch_set;
        end
    end

    assign status = {12'b0, bad_ch_reg, underflow_reg, overflow_reg, rx_busy};
endmodule

// File: tb/tb_xem_pipe_channel_bridge.sv
// Scoreboard bench for xem_pipe_channel_bridge (4 channels, 4-deep FIFOs, 2-word bursts).
module tb_xem_pipe_channel_bridge;
    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        ti_in_data_en = 1'b0;
    logic [15:0] ti_in_data = '0;
    logic [15:0] ti_in_available;
    logic        ti_out_data_en = 1'b0;
    logic [15:0] ti_out_data;
    logic [15:0] ti_out_available;
    logic [3:0]  ch_rx_valid;
    logic [15:0] ch_rx_data;
    logic [3:0]  ch_rx_ready = '0;
    logic [3:0]  ch_tx_valid = '0;
    logic [63:0] ch_tx_data = {16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00};
    logic [3:0]  ch_tx_ready;
    logic [15:0] status;

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] data;
    } rx_item_t;

    rx_item_t    exp_rx[$];
    logic [15:0] exp_tx[$];
    rx_item_t    mon_item;
    logic [15:0] mon_word;
    int          budget [4] = '{0, 0, 0, 0};
    logic [3:0]  hs;
    int          tests = 0;
    int          fails = 0;

    xem_pipe_channel_bridge #(.NUM_CH(4), .BUFF_ADDR_WIDTH(2), .BURST_LEN(2)) dut (
        .ti_clk(clk), .ti_soft_rst(srst),
        .ti_in_data_en(ti_in_data_en), .ti_in_data(ti_in_data), .ti_in_available(ti_in_available),
        .ti_out_data_en(ti_out_data_en), .ti_out_data(ti_out_data), .ti_out_available(ti_out_available),
        .ch_rx_valid(ch_rx_valid), .ch_rx_data(ch_rx_data), .ch_rx_ready(ch_rx_ready),
        .ch_tx_valid(ch_tx_valid), .ch_tx_data(ch_tx_data), .ch_tx_ready(ch_tx_ready),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else
            $display("[TB] ok   %s = %0h", name, act);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        ti_in_data_en = 1'b1;
        ti_in_data    = d;
        tick(1);
        ti_in_data_en = 1'b0;
    endtask

    task automatic expect_rx(input logic [3:0] ch, input logic [15:0] d);
        exp_rx.push_back({ch, d});
    endtask

    function automatic bit budgets_done();
        return (budget[0] + budget[1] + budget[2] + budget[3]) == 0;
    endfunction

    task automatic wait_rx(input int max_cyc);
        int n = 0;
        while (exp_rx.size() != 0 && n < max_cyc) begin
            tick(1);
            n++;
        end
        check("rx_drain", exp_rx.size(), 0);
    endtask

    // Host reads whenever words are stored, until the expected stream is consumed.
    task automatic run_tx(input int max_cyc);
        int n = 0;
        while (n < max_cyc && !(exp_tx.size() == 0 && ti_out_available == 0 && budgets_done())) begin
            ti_out_data_en = (ti_out_available != 0);
            tick(1);
            n++;
        end
        ti_out_data_en = 1'b0;
        check("tx_drain", exp_tx.size(), 0);
    endtask

    // Channel sources: each offers data until its word budget is used up.
    initial begin
        forever begin
            @(negedge clk);
            hs = ch_tx_valid & ch_tx_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < 4; c++) begin
                if (hs[c] && budget[c] > 0)
                    budget[c]--;
                ch_tx_valid[c] = (budget[c] != 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!srst && |(ch_rx_valid & ch_rx_ready)) begin
            if (exp_rx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rx_unexpected: got valid=%b data=%h, expected no delivery", ch_rx_valid, ch_rx_data);
            end else begin
                mon_item = exp_rx.pop_front();
                check("rx_route", 32'(ch_rx_valid), 32'(1) << mon_item.ch);
                check("rx_data", 32'(ch_rx_data), 32'(mon_item.data));
            end
        end
    end

    always @(negedge clk) begin
        if (!srst && ti_out_data_en) begin
            if (ti_out_available == 0)
                check("underflow_data", 32'(ti_out_data), 32'h0);
            else if (exp_tx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got %h, expected no word", ti_out_data);
            end else begin
                mon_word = exp_tx.pop_front();
                check("tx_word", 32'(ti_out_data), 32'(mon_word));
            end
        end
    end

    initial begin
        tick(3);
        srst = 1'b0;
        check("rst_in_avail", ti_in_available, 4);
        check("rst_out_avail", ti_out_available, 0);
        check("rst_out_data", ti_out_data, 0);
        check("rst_rx_valid", ch_rx_valid, 0);
        check("rst_tx_ready", ch_tx_ready, 0);
        check("rst_status", status, 0);

        // Routing to channel 2
        ch_rx_ready = 4'b0100;
        expect_rx(2, 16'hA0A1); expect_rx(2, 16'hB0B1); expect_rx(2, 16'hC0C1);
        push_word(16'h2003); push_word(16'hA0A1); push_word(16'hB0B1); push_word(16'hC0C1);
        wait_rx(20);
        tick(2);
        check("route_status", status, 16'h0000);

        // Bad channel is dropped, zero length skipped
        ch_rx_ready = 4'b1111;
        expect_rx(0, 16'h5A5A);
        push_word(16'h9002); push_word(16'h1111); push_word(16'h2222);
        push_word(16'h1000); push_word(16'h0001); push_word(16'h5A5A);
        wait_rx(20);
        tick(2);
        check("badch_status", status, 16'h0008);

        // Overflow: header is consumed, four payload words fill the FIFO, fifth is lost
        ch_rx_ready = 4'b0000;
        for (int i = 0; i < 6; i++)
            push_word((i == 0) ? 16'h1004 : 16'(16'h0100 + i));
        check("ovf_in_avail", ti_in_available, 0);
        check("ovf_status", status, 16'h000B);
        for (int i = 1; i <= 4; i++)
            expect_rx(1, 16'(16'h0100 + i));
        ch_rx_ready = 4'b0010;
        wait_rx(20);
        tick(2);
        check("ovf_drained_status", status, 16'h000A);
        check("ovf_drained_avail", ti_in_available, 4);

        // Underflow
        check("udf_out_avail", ti_out_available, 0);
        ti_out_data_en = 1'b1;
        tick(1);
        ti_out_data_en = 1'b0;
        check("udf_status", status, 16'h000E);

        // Round robin over all channels, channel 0 twice
        for (int k = 0; k < 5; k++) begin
            exp_tx.push_back(16'(((k % 4) << 12) | 2));
            exp_tx.push_back(16'(16'h0C00 + (k % 4)));
            exp_tx.push_back(16'(16'h0C00 + (k % 4)));
        end
        budget = '{4, 2, 2, 2};
        run_tx(300);

        // Space gating: 2 stored words leave too little room for a 3-word burst
        exp_tx.push_back(16'h1002); exp_tx.push_back(16'h0C01); exp_tx.push_back(16'h0C01);
        exp_tx.push_back(16'h2002); exp_tx.push_back(16'h0C02); exp_tx.push_back(16'h0C02);
        budget = '{0, 2, 2, 0};
        tick(8);
        check("gate_out_avail3", ti_out_available, 3);
        check("gate_ready_full", ch_tx_ready, 0);
        ti_out_data_en = 1'b1;
        tick(1);
        ti_out_data_en = 1'b0;
        check("gate_out_avail2", ti_out_available, 2);
        tick(5);
        check("gate_no_grant", ch_tx_ready, 0);
        check("gate_hold_avail", ti_out_available, 2);
        ti_out_data_en = 1'b1;
        tick(1);
        ti_out_data_en = 1'b0;
        run_tx(100);

        // Reset in the middle of a burst and a packet
        budget = '{0, 0, 0, 1};
        ch_rx_ready = 4'b1000;
        expect_rx(3, 16'hD1D1);
        push_word(16'h3003); push_word(16'hD1D1);
        tick(6);
        check("mid_tx_ready", ch_tx_ready, 4'b1000);
        check("mid_out_avail", ti_out_available, 2);
        check("mid_status", status, 16'h000F);
        check("mid_rx_done", exp_rx.size(), 0);
        srst = 1'b1;
        tick(2);
        srst = 1'b0;
        check("rst2_in_avail", ti_in_available, 4);
        check("rst2_out_avail", ti_out_available, 0);
        check("rst2_out_data", ti_out_data, 0);
        check("rst2_status", status, 0);
        check("rst2_rx_valid", ch_rx_valid, 0);
        check("rst2_tx_ready", ch_tx_ready, 0);
        exp_tx.push_back(16'h0002); exp_tx.push_back(16'h0C00); exp_tx.push_back(16'h0C00);
        exp_tx.push_back(16'h1002); exp_tx.push_back(16'h0C01); exp_tx.push_back(16'h0C01);
        budget = '{2, 2, 0, 0};
        ch_rx_ready = 4'b0001;
        expect_rx(0, 16'hE0E0);
        push_word(16'h0001); push_word(16'hE0E0);
        run_tx(100);
        wait_rx(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
